// File: rtl/oam_line_scanner.sv
// oam_line_scanner: per-line OAM search engine.
// On a start pulse, reads every OAM entry once, tests its Y against the latched line for 8x8 or
// 8x16 sprites and stores up to MaxPerLine hits (OAM index, X, row within sprite) in OAM order.
// The stored hits are exposed through a combinational random-access read port.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              1-cycle pulse, begins a search (ignored unless idle)
//   line_i               LY for the search, sampled with start_i
//   sprite_size_i        0 = 8x8, 1 = 8x16, sampled with start_i
//   sprite_enable_i      sprite enable, sampled with start_i
//   oam_rd_o/oam_addr_o  OAM read strobe and entry index
//   oam_y_i/oam_x_i      Y/X of the entry addressed in the previous cycle
//   busy_o, done_o       search in progress / 1-cycle completion pulse
//   hit_count_o          hits stored for this line
//   overflow_o           more than MaxPerLine hits on this line (sticky until next start)
//   rd_idx_i             hit-buffer read select
//   rd_oam_index_o, rd_x_o, rd_row_o  contents of hit rd_idx_i
module oam_line_scanner #(
  parameter int unsigned NumSprites = 40,
  parameter int unsigned MaxPerLine = 10,
  parameter int unsigned YOffset    = 16,
  localparam int unsigned IW = (NumSprites > 1) ? $clog2(NumSprites) : 1,
  localparam int unsigned CW = $clog2(MaxPerLine + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [7:0]    line_i,
  input  logic          sprite_size_i,
  input  logic          sprite_enable_i,
  output logic          oam_rd_o,
  output logic [IW-1:0] oam_addr_o,
  input  logic [7:0]    oam_y_i,
  input  logic [7:0]    oam_x_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] hit_count_o,
  output logic          overflow_o,
  input  logic [CW-1:0] rd_idx_i,
  output logic [IW-1:0] rd_oam_index_o,
  output logic [7:0]    rd_x_o,
  output logic [3:0]    rd_row_o
);

  // Buffer is sized to the full read-select range so any rd_idx_i is a legal index;
  // slots at or above MaxPerLine are never written and read back as zero.
  localparam int unsigned   Slots    = 2 ** CW;
  localparam logic [IW-1:0] LastAddr = IW'(NumSprites - 1);
  localparam logic [CW-1:0] MaxCount = CW'(MaxPerLine);
  localparam logic [8:0]    YOff9    = 9'(YOffset);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] addr_q, addr_d;
  logic [7:0]    line_q, line_d;
  logic          size_q, size_d;
  logic          en_q, en_d;
  logic          eval_q, eval_d;          // oam_y_i/oam_x_i carry a freshly read entry
  logic [IW-1:0] eval_idx_q, eval_idx_d;  // index of that entry
  logic [CW-1:0] hit_count_q, hit_count_d;
  logic          ovf_q, ovf_d;

  logic [IW-1:0] idx_mem_q [Slots];
  logic [7:0]    x_mem_q   [Slots];
  logic [3:0]    row_mem_q [Slots];

  logic [8:0] diff;
  logic       hit;
  logic       wr_en;

  // A Y below the line bias wraps to a large value and never hits.
  assign diff = {1'b0, line_q} + YOff9 - {1'b0, oam_y_i};
  assign hit  = eval_q && en_q && (diff < (size_q ? 9'd16 : 9'd8));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    line_d      = line_q;
    size_d      = size_q;
    en_d        = en_q;
    hit_count_d = hit_count_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;
    eval_d      = (state_q == StScan);
    eval_idx_d  = addr_q;

    if (hit) begin
      if (hit_count_q < MaxCount) begin
        wr_en       = 1'b1;
        hit_count_d = hit_count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StScan;
          addr_d      = '0;
          line_d      = line_i;
          size_d      = sprite_size_i;
          en_d        = sprite_enable_i;
          hit_count_d = '0;
          ovf_d       = 1'b0;
        end
      end
      StScan: begin
        if (addr_q == LastAddr) begin
          state_d = StDrain;
        end else begin
          addr_d = addr_q + IW'(1);
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      line_q      <= '0;
      size_q      <= 1'b0;
      en_q        <= 1'b0;
      eval_q      <= 1'b0;
      eval_idx_q  <= '0;
      hit_count_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      line_q      <= line_d;
      size_q      <= size_d;
      en_q        <= en_d;
      eval_q      <= eval_d;
      eval_idx_q  <= eval_idx_d;
      hit_count_q <= hit_count_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Slots; i++) begin
        idx_mem_q[i] <= '0;
        x_mem_q[i]   <= '0;
        row_mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      idx_mem_q[hit_count_q] <= eval_idx_q;
      x_mem_q[hit_count_q]   <= oam_x_i;
      row_mem_q[hit_count_q] <= diff[3:0];
    end
  end

  assign oam_rd_o       = (state_q == StScan);
  assign oam_addr_o     = addr_q;
  assign busy_o         = (state_q == StScan) || (state_q == StDrain);
  assign done_o         = (state_q == StDone);
  assign hit_count_o    = hit_count_q;
  assign overflow_o     = ovf_q;
  assign rd_oam_index_o = idx_mem_q[rd_idx_i];
  assign rd_x_o         = x_mem_q[rd_idx_i];
  assign rd_row_o       = row_mem_q[rd_idx_i];

endmodule

// File: tb/tb_oam_line_scanner.sv
// Scoreboard bench for oam_line_scanner: two instances (40/10 and 8/2), a registered OAM model,
// a reference search model pushing expected results, and monitors checking each done pulse.
module tb_oam_line_scanner;

  localparam int NA = 40, MA = 10, NB = 8, MB = 2;

  typedef struct {
    int cnt;
    int ovf;
    int done_cyc;
    int idx[10];
    int x[10];
    int row[10];
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A signals
  logic       start_a, size_a, en_a, oam_rd_a, busy_a, done_a, ovf_a;
  logic [7:0] line_a, oy_a, ox_a, rd_x_a;
  logic [5:0] oam_addr_a, rd_oam_a;
  logic [3:0] cnt_a, rd_idx_a, rd_row_a;
  // DUT B signals
  logic       start_b, size_b, en_b, oam_rd_b, busy_b, done_b, ovf_b;
  logic [7:0] line_b, oy_b, ox_b, rd_x_b;
  logic [2:0] oam_addr_b, rd_oam_b;
  logic [1:0] cnt_b, rd_idx_b;
  logic [3:0] rd_row_b;

  logic [7:0] ya [NA];
  logic [7:0] xa [NA];
  logic [7:0] yb [NB];
  logic [7:0] xb [NB];

  exp_t q_a[$];
  exp_t q_b[$];

  oam_line_scanner #(.NumSprites(NA), .MaxPerLine(MA), .YOffset(16)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .line_i(line_a),
    .sprite_size_i(size_a), .sprite_enable_i(en_a), .oam_rd_o(oam_rd_a),
    .oam_addr_o(oam_addr_a), .oam_y_i(oy_a), .oam_x_i(ox_a), .busy_o(busy_a),
    .done_o(done_a), .hit_count_o(cnt_a), .overflow_o(ovf_a), .rd_idx_i(rd_idx_a),
    .rd_oam_index_o(rd_oam_a), .rd_x_o(rd_x_a), .rd_row_o(rd_row_a)
  );

  oam_line_scanner #(.NumSprites(NB), .MaxPerLine(MB), .YOffset(16)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .line_i(line_b),
    .sprite_size_i(size_b), .sprite_enable_i(en_b), .oam_rd_o(oam_rd_b),
    .oam_addr_o(oam_addr_b), .oam_y_i(oy_b), .oam_x_i(ox_b), .busy_o(busy_b),
    .done_o(done_b), .hit_count_o(cnt_b), .overflow_o(ovf_b), .rd_idx_i(rd_idx_b),
    .rd_oam_index_o(rd_oam_b), .rd_x_o(rd_x_b), .rd_row_o(rd_row_b)
  );

  // OAM returns the addressed entry one cycle after the read strobe.
  always @(posedge clk) begin
    if (oam_rd_a) begin
      oy_a <= ya[oam_addr_a];
      ox_a <= xa[oam_addr_a];
    end
    if (oam_rd_b) begin
      oy_b <= yb[oam_addr_b];
      ox_b <= xb[oam_addr_b];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a sprite covers lines [Y-16, Y-16+height); hits kept in OAM order up to the cap.
  function automatic exp_t model(input bit b, input int ln, input bit sz, input bit en,
                                 input int t0);
    exp_t e;
    int n, m, d, y;
    n = b ? NB : NA;
    m = b ? MB : MA;
    e.cnt = 0;
    e.ovf = 0;
    e.done_cyc = t0 + n + 1;
    for (int k = 0; k < 10; k++) begin
      e.idx[k] = 0;
      e.x[k]   = 0;
      e.row[k] = 0;
    end
    for (int i = 0; i < n; i++) begin
      if (b) y = int'(yb[i]);
      else   y = int'(ya[i]);
      d = ln + 16 - y;
      if (en && d >= 0 && d < (sz ? 16 : 8)) begin
        if (e.cnt < m) begin
          e.idx[e.cnt] = i;
          e.x[e.cnt]   = b ? int'(xb[i]) : int'(xa[i]);
          e.row[e.cnt] = d;
          e.cnt++;
        end else begin
          e.ovf = 1;
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && done_a) begin
      if (q_a.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL a_unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        e = q_a.pop_front();
        chk("a_done_cycle", cyc, e.done_cyc);
        chk("a_busy_at_done", int'(busy_a), 0);
        chk("a_hit_count", int'(cnt_a), e.cnt);
        chk("a_overflow", int'(ovf_a), e.ovf);
        for (int i = 0; i < e.cnt; i++) begin
          rd_idx_a = 4'(i);
          #1;
          chk("a_rd_oam_index", int'(rd_oam_a), e.idx[i]);
          chk("a_rd_x", int'(rd_x_a), e.x[i]);
          chk("a_rd_row", int'(rd_row_a), e.row[i]);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && done_b) begin
      if (q_b.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL b_unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        e = q_b.pop_front();
        chk("b_done_cycle", cyc, e.done_cyc);
        chk("b_hit_count", int'(cnt_b), e.cnt);
        chk("b_overflow", int'(ovf_b), e.ovf);
        for (int i = 0; i < e.cnt; i++) begin
          rd_idx_b = 2'(i);
          #1;
          chk("b_rd_oam_index", int'(rd_oam_b), e.idx[i]);
          chk("b_rd_x", int'(rd_x_b), e.x[i]);
          chk("b_rd_row", int'(rd_row_b), e.row[i]);
        end
      end
    end
  end

  task automatic wait_done(input bit b);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (b ? done_b : done_a) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL done_timeout: got no done in 200 cycles, expected done (dut %0d)", b);
    end
  endtask

  // One search; poke > 0 re-pulses start that many cycles into the scan (must be ignored).
  task automatic run(input bit b, input int ln, input bit sz, input bit en, input int poke);
    int t0;
    @(negedge clk);
    t0 = cyc + 1;
    if (b) begin
      start_b = 1'b1; line_b = 8'(ln); size_b = sz; en_b = en;
      q_b.push_back(model(1'b1, ln, sz, en, t0));
    end else begin
      start_a = 1'b1; line_a = 8'(ln); size_a = sz; en_a = en;
      q_a.push_back(model(1'b0, ln, sz, en, t0));
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    // Disturb the sampled inputs; the DUT must use its latched copies.
    line_a = 8'($urandom); size_a = ~sz; en_a = ~en;
    line_b = 8'($urandom); size_b = ~sz; en_b = ~en;
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      if (b) start_b = 1'b1;
      else   start_a = 1'b1;
      line_a = 8'($urandom); line_b = 8'($urandom);
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
    end
    wait_done(b);
    @(negedge clk);
  endtask

  task automatic fill_a(input logic [7:0] y);
    for (int i = 0; i < NA; i++) begin
      ya[i] = y;
      xa[i] = 8'($urandom);
    end
  endtask

  initial begin
    int ln;
    rst_n = 1'b0;
    start_a = 1'b0; line_a = '0; size_a = 1'b0; en_a = 1'b0; rd_idx_a = '0;
    start_b = 1'b0; line_b = '0; size_b = 1'b0; en_b = 1'b0; rd_idx_b = '0;
    fill_a(8'd0);
    for (int i = 0; i < NB; i++) begin
      yb[i] = 8'd0;
      xb[i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_oam_rd", int'(oam_rd_a), 0);
    chk("rst_oam_addr", int'(oam_addr_a), 0);
    chk("rst_hit_count", int'(cnt_a), 0);
    chk("rst_overflow", int'(ovf_a), 0);
    chk("rst_rd_x", int'(rd_x_a), 0);
    chk("rst_rd_row", int'(rd_row_a), 0);
    chk("rst_rd_oam_index", int'(rd_oam_a), 0);
    rst_n = 1'b1;

    // Single hit, 8x8, line 0: entry 5 at Y=16 -> row 0.
    fill_a(8'd0);
    ya[5] = 8'd16;
    run(1'b0, 0, 1'b0, 1'b1, 0);

    // 8x16, line 20: Y=21 -> row 15, Y=36 -> row 0, Y=37 wraps and misses.
    fill_a(8'd0);
    ya[3] = 8'd21; ya[7] = 8'd36; ya[9] = 8'd37;
    run(1'b0, 20, 1'b1, 1'b1, 0);

    // Twelve hits against a ten-entry buffer.
    fill_a(8'd0);
    for (int i = 0; i < 12; i++) ya[i * 3] = 8'd16;
    run(1'b0, 0, 1'b0, 1'b1, 0);

    // Disabled sprites on matching OAM, with a start pulse mid-scan that must be ignored.
    fill_a(8'd66);
    run(1'b0, 50, 1'b1, 1'b0, 10);
    run(1'b0, 50, 1'b1, 1'b1, 0);

    // Reset mid-scan: immediate return to reset values, no done pulse.
    fill_a(8'd40);
    @(negedge clk);
    start_a = 1'b1; line_a = 8'd30; size_a = 1'b1; en_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_oam_rd", int'(oam_rd_a), 0);
    chk("midrst_hit_count", int'(cnt_a), 0);
    chk("midrst_overflow", int'(ovf_a), 0);
    chk("midrst_rd_x", int'(rd_x_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    run(1'b0, 30, 1'b1, 1'b1, 0);

    // Small instance: Y=line+6 is 10 lines down, visible only for 8x16; Y=line+9 hits both.
    yb[2] = 8'd56; yb[4] = 8'd59;
    run(1'b1, 50, 1'b0, 1'b1, 0);
    run(1'b1, 50, 1'b1, 1'b1, 0);
    for (int i = 0; i < NB; i++) yb[i] = 8'd60;
    run(1'b1, 50, 1'b0, 1'b1, 0);

    // Randomized searches near the line on both instances.
    for (int t = 0; t < 8; t++) begin
      ln = int'($urandom_range(0, 150));
      for (int i = 0; i < NA; i++) begin
        ya[i] = 8'(ln + 16 - int'($urandom_range(0, 40)));
        xa[i] = 8'($urandom);
      end
      for (int i = 0; i < NB; i++) begin
        yb[i] = 8'(ln + 16 - int'($urandom_range(0, 20)));
        xb[i] = 8'($urandom);
      end
      run(1'b0, ln, 1'($urandom), ($urandom_range(0, 5) != 0), 0);
      run(1'b1, ln, 1'($urandom), 1'b1, 0);
    end

    repeat (4) @(negedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL pending_results: got %0d/%0d unchecked, expected 0/0", q_a.size(),
               q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
